slow_clock_monitor: RTL

//  Receiving end of the divided "slow" clock: samples the divider output in the clkIn domain,

---
 rtl/slow_clock_pkg.sv | 16 +
 rtl/sync_edge_detect.sv | 38 +++
 rtl/slow_clock_monitor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/slow_clock_pkg.sv
// Shared types and constants for the slow-clock monitor: FSM states and fault codes.
package slow_clock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACQUIRE,
    TRACK,
    LOCKED,
    FAULT
  } state_t;

  localparam logic [1:0] FAULT_NONE  = 2'b00;
  localparam logic [1:0] FAULT_STALL = 2'b01;
  localparam logic [1:0] FAULT_FAST  = 2'b10;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus history flop; registered rise/fall pulses, masked for the
// first three cycles after reset release so power-up levels never look like edges.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic       sync_1;
  logic       sync_2;
  logic       hist;
  logic [1:0] mask_cnt;
  logic       armed;

  assign armed = (mask_cnt == 2'd3);

  // NOTE: sequential state uses non-blocking assignments and an async active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      hist     <= 1'b0;
      mask_cnt <= 2'd0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      hist   <= sync_2;
      if (!armed) mask_cnt <= mask_cnt + 2'd1;
      rise <= armed &  sync_2 & ~hist;
      fall <= armed & ~sync_2 &  hist;
    end
  end

endmodule

// File: rtl/slow_clock_monitor.sv
// Measures each half-period of the divided slow clock, checks it against the expected
// ratio, and reports ticks, full period, lock and sticky fault status.
module slow_clock_monitor
  import slow_clock_pkg::*;
#(
  parameter int HALF_PERIOD = 6,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clkIn,
  input  logic             reset,
  input  logic             slowIn,
  input  logic             enable,
  output logic             tickRise,
  output logic             tickFall,
  output logic [CNT_W-1:0] period,
  output logic             periodValid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       faultCode
);

  localparam logic [CNT_W:0]   M_LO     = (CNT_W+1)'(HALF_PERIOD - TOL);
  localparam logic [CNT_W:0]   M_HI     = (CNT_W+1)'(HALF_PERIOD + TOL);
  localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(HALF_PERIOD + TOL);
  localparam logic [CNT_W-1:0] LOCK_AT  = CNT_W'(LOCK_COUNT);

  state_t           state;
  state_t           next_state;
  logic             rise;
  logic             fall;
  logic             any_edge;
  logic             active;
  logic             checking;
  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] good_cnt;
  logic [CNT_W-1:0] m_fall;
  logic             fall_valid;
  logic [CNT_W:0]   m;
  logic             m_good;
  logic             stall;
  logic             bad_edge;

  sync_edge_detect u_sync (
    .clk  (clkIn),
    .rst_n(reset),
    .din  (slowIn),
    .rise (rise),
    .fall (fall)
  );

  // Dropping enable overrides everything in the same cycle, including a coincident edge.
  assign active   = enable && (state != IDLE);
  assign checking = enable && (state == TRACK || state == LOCKED);
  assign any_edge = rise || fall;
  assign m        = {1'b0, half_cnt} + 1'b1;
  assign m_good   = (m >= M_LO) && (m <= M_HI);
  assign stall    = checking && !any_edge && (half_cnt == STALL_AT);
  assign bad_edge = checking && any_edge && !m_good;

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    next_state = ACQUIRE;
        ACQUIRE: if (any_edge) next_state = TRACK;
        TRACK: begin
          if (bad_edge || stall)                             next_state = FAULT;
          else if (any_edge && (good_cnt + 1'b1 == LOCK_AT)) next_state = LOCKED;
        end
        LOCKED:  if (bad_edge || stall) next_state = FAULT;
        FAULT:   next_state = FAULT;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    tickRise = active && rise;
    tickFall = active && fall;
    locked   = (state == LOCKED);
    fault    = (state == FAULT);
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      faultCode <= FAULT_NONE;
    end else if (next_state == IDLE) begin
      faultCode <= FAULT_NONE;
    end else if (state != FAULT && next_state == FAULT) begin
      // An edge arriving exactly at the timeout is judged by its measured length.
      faultCode <= (bad_edge && m < M_LO) ? FAULT_FAST : FAULT_STALL;
    end
  end

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      half_cnt    <= '0;
      good_cnt    <= '0;
      m_fall      <= '0;
      fall_valid  <= 1'b0;
      period      <= '0;
      periodValid <= 1'b0;
    end else if (!active) begin
      half_cnt    <= '0;
      good_cnt    <= '0;
      m_fall      <= '0;
      fall_valid  <= 1'b0;
      period      <= '0;
      periodValid <= 1'b0;
    end else begin
      if (any_edge)            half_cnt <= '0;
      else if (half_cnt != '1) half_cnt <= half_cnt + 1'b1;
      if (state == TRACK && any_edge && m_good) good_cnt <= good_cnt + 1'b1;
      if (checking && fall) begin
        m_fall     <= m[CNT_W-1:0];
        fall_valid <= 1'b1;
      end
      periodValid <= checking && rise && fall_valid;
      if (checking && rise && fall_valid) period <= m_fall + m[CNT_W-1:0];
    end
  end

endmodule
